fetch_queue: RTL and testbench

Instruction prefetch buffer between instruction memory and the IF/ID pipeline register. It issues sequential fetch addresses to a 1-cycle-latency instruction memory and holds returned instruction/PC pairs in a small FIFO. It presents the head entry to decode, honouring the hazard-unit stall. On a branch or jump redirect it discards all queued and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch to a 1-cycle imem, FIFO of instr/PC pairs, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a returning instruction straight to decode when the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             fetch_req,
    output logic [WIDTH-1:0] fetch_pc,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_instr_q, last_instr_d;
    logic [WIDTH-1:0] last_pc_q, last_pc_d;

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic             issue;
    logic             head_valid;
    logic             bypass_hit;
    logic             bypass_take;
    logic             push;
    logic             pop;

    // Issue credit uses registered occupancy only; a pop in this cycle does not free a slot yet.
    always_comb begin
        issue     = !reset && !redirect &&
                    (((CW+1)'(count_q) + (CW+1)'(inflight_q)) < DEPTH_C);
        fetch_req = issue;
        fetch_pc  = fetch_pc_q;
    end

    always_comb begin
        head_valid = (count_q != '0);
        bypass_hit = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = !head_valid && inflight_q && !redirect;
`endif
        bypass_take = bypass_hit && !stall;
        instr_valid = head_valid || bypass_hit;

        if (head_valid) begin
            instr_out = instr_mem_q[rd_ptr_q];
            instr_pc  = pc_mem_q[rd_ptr_q];
        end else if (bypass_hit) begin
            instr_out = imem_data;
            instr_pc  = inflight_pc_q;
        end else begin
            instr_out = last_instr_q;
            instr_pc  = last_pc_q;
        end

        pop  = head_valid && !stall && !redirect;
        push = inflight_q && !redirect && !bypass_take;
    end

    always_comb begin
        last_instr_d  = instr_valid ? instr_out : last_instr_q;
        last_pc_d     = instr_valid ? instr_pc  : last_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        fetch_pc_d    = issue ? fetch_pc_q + WIDTH'(1) : fetch_pc_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            last_instr_q  <= '0;
            last_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            last_instr_q  <= last_instr_d;
            last_pc_q     <= last_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model, plus directed literal checks.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk;
    logic             reset;
    logic             fetch_req;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] imem_data;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             stall;
    logic             instr_valid;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] instr_pc;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of {instr, pc} entries plus at most one outstanding fetch.
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } ent_t;

    ent_t             mq[$];
    bit               m_inf;
    logic [WIDTH-1:0] m_inf_pc;
    logic [WIDTH-1:0] m_fpc;
    ent_t             m_last;

    always @(negedge clk) begin
        bit   byp;
        bit   exp_req;
        bit   exp_valid;
        ent_t head;
        if (reset) begin
            mq.delete();
            m_inf    = 0;
            m_inf_pc = '0;
            m_fpc    = '0;
            m_last   = '0;
            chk("rst_fetch_req", 32'(fetch_req), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);
        end else begin
            byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (mq.size() == 0) && m_inf && !redirect;
`endif
            exp_req   = !redirect && ((mq.size() + int'(m_inf)) < DEPTH);
            exp_valid = (mq.size() != 0) || byp;
            if (mq.size() != 0)  head = mq[0];
            else if (byp)        head = {m_inf_pc + 16'h1000, m_inf_pc};
            else                 head = m_last;

            chk("fetch_req", 32'(fetch_req), 32'(exp_req));
            chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
            chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
            chk("instr_out", 32'(instr_out), 32'(head.instr));
            chk("instr_pc", 32'(instr_pc), 32'(head.pc));

            if (exp_valid) m_last = head;
            if (redirect) begin
                mq.delete();
                m_fpc = redirect_pc;
            end else begin
                if (mq.size() != 0 && !stall) void'(mq.pop_front());
                if (m_inf && !(byp && !stall)) mq.push_back({m_inf_pc + 16'h1000, m_inf_pc});
            end
            m_inf = exp_req;
            if (exp_req) begin
                m_inf_pc = m_fpc;
                m_fpc    = m_fpc + 16'd1;
            end
            if (mq.size() > DEPTH) chk("model_depth", 32'(mq.size()), 32'(DEPTH));
        end
    end

    logic             req_s;
    logic [WIDTH-1:0] pc_s;

    // One cycle: drive inputs just after the edge, return to caller at the following negedge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [WIDTH-1:0] rpc);
        @(posedge clk);
        #1;
        imem_data   = req_s ? pc_s + 16'h1000 : 16'($urandom);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        req_s = fetch_req;
        pc_s  = fetch_pc;
    endtask

    initial begin
        logic [WIDTH-1:0] p;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_data = '0;
        req_s = 1'b0; pc_s = '0;
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);

        // Reset release and steady streaming
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            chk("seq_fetch_pc", 32'(fetch_pc), 32'(k));
            if (k >= LAT) begin
                chk("seq_valid", 32'(instr_valid), 32'd1);
                chk("seq_instr_pc", 32'(instr_pc), 32'(k - LAT));
                chk("seq_instr_out", 32'(instr_out), 32'(16'h1000 + 16'(k - LAT)));
            end else begin
                chk("seq_invalid", 32'(instr_valid), 32'd0);
            end
        end

        // Long stall fills the queue, then drains in order
        repeat (10) step(1'b0, 1'b1, 1'b0, '0);
        chk("full_no_req", 32'(fetch_req), 32'd0);
        chk("full_valid", 32'(instr_valid), 32'd1);
        p = instr_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            chk("drain_pc", 32'(instr_pc), 32'(p + 16'(i)));
        end

        // Redirect with a partly full queue and a fetch in flight
        repeat (2) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("redir_invalid", 32'(instr_valid), 32'd0);
        chk("redir_fetch_pc", 32'(fetch_pc), 32'h0040);
        repeat (LAT) step(1'b0, 1'b0, 1'b0, '0);
        chk("redir_valid", 32'(instr_valid), 32'd1);
        chk("redir_first_pc", 32'(instr_pc), 32'h0040);

        // Redirect while stalled with a full queue
        repeat (8) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 16'h0123);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("stall_redir_invalid", 32'(instr_valid), 32'd0);
        chk("stall_redir_fetch_pc", 32'(fetch_pc), 32'h0123);

        // PC wrap across 0xFFFF
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, '0);
        repeat (LAT) step(1'b0, 1'b0, 1'b0, '0);
        chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("wrap_pc1", 32'(instr_pc), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("wrap_pc2", 32'(instr_pc), 32'h0000);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("wrap_pc3", 32'(instr_pc), 32'h0001);
        chk("wrap_instr3", 32'(instr_out), 32'h1001);

        // Asynchronous reset mid-stream
        step(1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_req", 32'(fetch_req), 32'd0);
        chk("arst_out", 32'(instr_out), 32'd0);
        chk("arst_pc", 32'(instr_pc), 32'd0);
        chk("arst_fetch_pc", 32'(fetch_pc), 32'd0);
        @(negedge clk);
        req_s = fetch_req;
        pc_s  = fetch_pc;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("arst_restart_req", 32'(fetch_req), 32'd1);
        chk("arst_restart_pc", 32'(fetch_pc), 32'd0);

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            logic             s;
            logic             rd;
            logic [WIDTH-1:0] rpc;
            s   = ($urandom_range(0, 99) < ((c / 200) % 2 == 0 ? 30 : 70));
            rd  = ($urandom_range(0, 99) < 5);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            step(1'b0, s, rd, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
